// File: rtl/counter_run_controller.sv
// rtl/counter_run_controller.sv - run-control sequencer for a WIDTH-bit up-counter
//
// Sequences counting from 0 up to a terminal value latched at start.
// Supports one-shot and auto-reload modes, pause, and abort.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   start      - level-sampled start request (honoured in IDLE/DONE)
//   stop       - abort to IDLE, clears count
//   pause      - holds count while high in RUN
//   mode       - 0 one-shot, 1 auto-reload; latched at accepted start
//   limit      - terminal count; latched at accepted start
//   count      - current count value
//   busy       - high while in RUN
//   tc         - terminal-count flag (RUN, not paused, count == latched limit)
//   err        - one-cycle pulse when start is rejected for limit == 0
//   period_cnt - completed auto-reload periods, wraps
module counter_run_controller #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              tc,
    output logic              err,
    output logic [PCNT_W-1:0] period_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [WIDTH-1:0]   lim_q;
    logic [WIDTH-1:0]   lim_d;
    logic               mode_q;
    logic               mode_d;
    logic [WIDTH-1:0]   count_d;
    logic [PCNT_W-1:0]  pcnt_d;
    logic               err_d;

    assign busy = (state == RUN);
    assign tc   = (state == RUN) && !pause && (count == lim_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            lim_q      <= '0;
            mode_q     <= 1'b0;
            period_cnt <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            lim_q      <= lim_d;
            mode_q     <= mode_d;
            period_cnt <= pcnt_d;
            err        <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        lim_d   = lim_q;
        mode_d  = mode_q;
        pcnt_d  = period_cnt;
        err_d   = 1'b0;

        // stop outranks start and tc, so a stop on the tc cycle never bumps period_cnt
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (limit != '0) begin
                            state_d = RUN;
                            lim_d   = limit;
                            mode_d  = mode;
                            count_d = '0;
                            pcnt_d  = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tc) begin
                        if (mode_q) begin
                            count_d = '0;
                            pcnt_d  = period_cnt + PCNT_W'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end else if (!pause) begin
                        // tc covers count == lim_q, so this never passes the limit
                        count_d = count + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

endmodule
